// File: rtl/mmf_spike_monitor.sv
// Spike monitor for the mmf neuron core: hysteretic threshold detector, spike pulse,
// inter-spike interval measurement and windowed spike-rate reporting.
module mmf_spike_monitor #(
  parameter logic [7:0]  THRESH = 8'd200,
  parameter logic [7:0]  HYST   = 8'd20,
  parameter logic [15:0] WINDOW = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  state,
  input  logic        clear,
  output logic        spike,
  output logic [7:0]  spike_count,
  output logic [7:0]  rate,
  output logic        rate_valid,
  output logic [15:0] isi,
  output logic        isi_valid
);

  // Re-arm level floors at zero when HYST exceeds THRESH (borrow out of the 9-bit subtract).
  localparam logic [8:0]  REARM_DIFF = {1'b0, THRESH} - {1'b0, HYST};
  localparam logic [7:0]  REARM      = REARM_DIFF[8] ? 8'd0 : REARM_DIFF[7:0];
  localparam logic [15:0] WLAST      = WINDOW - 16'd1;

  typedef enum logic {ARMED, FIRED} det_state_t;

  det_state_t  det_state;
  logic [15:0] wcnt;
  logic [15:0] icnt;
  logic        first;

  logic        detect;
  logic        wrap;
  logic [7:0]  count_next;
  logic [15:0] icnt_inc;

  always_comb begin
    detect     = 1'b0;
    wrap       = 1'b0;
    count_next = spike_count;
    icnt_inc   = icnt;
    detect     = !clear && (det_state == ARMED) && (state >= THRESH);
    wrap       = (wcnt == WLAST);
    if (detect && (spike_count != 8'hFF))
      count_next = spike_count + 8'd1;
    if (icnt != 16'hFFFF)
      icnt_inc = icnt + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_state   <= ARMED;
      wcnt        <= 16'd0;
      icnt        <= 16'd0;
      first       <= 1'b1;
      spike       <= 1'b0;
      spike_count <= 8'd0;
      rate        <= 8'd0;
      rate_valid  <= 1'b0;
      isi         <= 16'd0;
      isi_valid   <= 1'b0;
    end else if (clear) begin
      // rate and isi keep their last reported values across a clear.
      det_state   <= ARMED;
      wcnt        <= 16'd0;
      icnt        <= 16'd0;
      first       <= 1'b1;
      spike       <= 1'b0;
      spike_count <= 8'd0;
      rate_valid  <= 1'b0;
      isi_valid   <= 1'b0;
    end else begin
      spike <= detect;

      case (det_state)
        ARMED:   if (state >= THRESH) det_state <= FIRED;
        FIRED:   if (state < REARM)   det_state <= ARMED;
        default: det_state <= ARMED;
      endcase

      // A spike on the wrap edge is folded into the closing window's total.
      if (wrap) begin
        wcnt        <= 16'd0;
        rate        <= count_next;
        spike_count <= 8'd0;
        rate_valid  <= 1'b1;
      end else begin
        wcnt        <= wcnt + 16'd1;
        spike_count <= count_next;
        rate_valid  <= 1'b0;
      end

      isi_valid <= 1'b0;
      if (detect) begin
        icnt  <= 16'd0;
        first <= 1'b0;
        if (!first) begin
          isi       <= icnt_inc;
          isi_valid <= 1'b1;
        end
      end else begin
        icnt <= icnt_inc;
      end
    end
  end

endmodule

// File: doc/mmf_spike_monitor.md
# mmf_spike_monitor

Downstream stage of the `mmf` neuron core: it consumes the 8-bit `state` bus the core produces each clock and turns it into spike events and activity statistics. It detects threshold crossings with hysteresis, emits a one-cycle spike pulse, measures the inter-spike interval and reports the spike rate per fixed window. Its outputs are intended for the top-level output pins and for an optional readout mux.

## Interface

Parameters:

- `THRESH`, 8'd200: unsigned spike threshold on `state`.
- `HYST`, 8'd20: re-arm hysteresis. Re-arm level is `THRESH-HYST`, floored at 0.
- `WINDOW`, 16'd1000: rate window length in cycles. Legal range 1..65535.

Ports:

- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `state`  in  8: unsigned membrane state from `mmf`, sampled every edge.
- `clear`  in  1: synchronous restart of detector, window and ISI tracking; `rate` and `isi` are held.
- `spike`  out  1: one-cycle pulse per detected spike.
- `spike_count`  out  8: spikes in the current window, saturating at 255.
- `rate`  out  8: spike count of the last completed window.
- `rate_valid`  out  1: one-cycle pulse when `rate` updates.
- `isi`  out  16: cycles between the last two spikes, saturating at 16'hFFFF.
- `isi_valid`  out  1: one-cycle pulse when `isi` updates.

## Operation

- **Detector FSM**, two states:
  - ARMED to FIRED when sampled `state >= THRESH`. That edge is a *detection edge*.
  - FIRED to ARMED when `state < re-arm level`.
  - No other transitions. Staying above threshold produces exactly one spike.
- **Spike output:** `spike` is registered and goes high for the one cycle that follows a detection edge.
- **Window counter** `wcnt` (16 bit):
  - Counts 0..WINDOW-1 and wraps to 0.
  - On the wrap edge, `rate` takes the window total including any spike detected on that same edge. In the same edge `spike_count` is set to 0 and `rate_valid` pulses.
  - `spike_count` increments on each detection edge, saturating at 255.
- **ISI counter** `icnt` (16 bit):
  - Set to 0 on a detection edge; otherwise increments by 1 per edge, saturating at 16'hFFFF.
  - On a detection edge, `isi` is set to `min(icnt+1, 16'hFFFF)` and `isi_valid` pulses. Consecutive detection edges N and N+k therefore give `isi = k`.
  - `first` flag: the first detection after reset or `clear` gives no `isi_valid` and leaves `isi` unchanged. It only starts `icnt`.
- **`clear`** (synchronous):
  - Sets FSM to ARMED and `wcnt`, `spike_count`, `icnt` to 0, and sets `first`.
  - Suppresses detection on the same edge. `spike`, `rate_valid` and `isi_valid` are low the next cycle.
- **Reset values:** all outputs are 0. Internally FSM = ARMED, `wcnt` = 0, `icnt` = 0, `first` = 1.
- **Reset mid-operation:** takes effect immediately and asynchronously. A partially counted window is discarded.

## Timing

- `state` is sampled at edge N; the outputs it causes are visible after edge N with no extra pipeline stage. `spike`, `spike_count`, `isi` and `isi_valid` update from edge N.
- Minimum spike spacing is 2 cycles: one cycle with `state` above threshold, one below the re-arm level.
- With `WINDOW = W`, `rate_valid` pulses every W cycles. The first pulse comes W cycles after reset is released.
- **Simultaneous events:**
  - Detection on a wrap edge: the spike counts in the closing window, `rate_valid` and `spike` are both high, and the new `spike_count` is 0.
  - `clear` on a wrap edge: `clear` wins and there is no `rate_valid`.
- **Width rules:** all compares are unsigned 8-bit. Compute the re-arm level with a 9-bit subtract and clamp negative results to 0.

## Test plan

1. **Reset values:** assert `reset` mid-window with `state` = 250. Every output is 0 immediately. After release, hold `state` = 250 for 5 cycles: exactly one `spike` pulse, and `spike_count` = 1.
2. **Hysteresis:** drive `state` 210, 185, 210, 175, 210. Spikes occur only on the 1st and 5th samples; 185 does not re-arm.
3. **ISI measurement:** spikes detected at edges 10, 17, 17+70000. There is no `isi_valid` at edge 10, then `isi` = 7 with `isi_valid` at edge 17, then `isi` = 16'hFFFF.
4. **Rate window:** with `WINDOW` = 20, toggle `state` 0/255 every cycle. Every 20 cycles `rate_valid` pulses with `rate` = 10. Place one detection on the wrap edge and check it is counted in the closing window.
5. **Saturation:** with `WINDOW` = 1000, toggle every cycle. `spike_count` stops at 255 and `rate` = 255.
6. **Clear:** pulse `clear` while FIRED with `spike_count` = 4. The next cycle shows `spike_count` = 0 and FSM ARMED, and `rate` and `isi` are unchanged. The next detection gives no `isi_valid`.
